// File: rtl/dmux_pkg.sv
// Shared select-code definitions for the dmux gate-library family.
package dmux_pkg;

   localparam int SEL_W = 2;

   localparam logic [SEL_W-1:0] SEL_A = 2'b00;
   localparam logic [SEL_W-1:0] SEL_B = 2'b01;
   localparam logic [SEL_W-1:0] SEL_C = 2'b10;
   localparam logic [SEL_W-1:0] SEL_D = 2'b11;

endpackage

// File: rtl/dmux2way_cell.sv
// Combinational 1-to-2 demux: routes in to lo when sel is 0, to hi when sel is 1.
module dmux2way_cell #(
   parameter int WIDTH = 1
) (
   input  logic             sel,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   // Steer in to one leg and zero the other.
   always_comb begin
      lo = '0;
      hi = '0;
      if (sel) begin
         hi = in;
      end else begin
         lo = in;
      end
   end

endmodule

// File: rtl/dmux4way.sv
// Registered 1-to-4 demux built from a two-level dmux2way_cell tree.
module dmux4way
   import dmux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in,
   input  logic [SEL_W-1:0] sel,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] d
);

   logic [WIDTH-1:0] ab_s;
   logic [WIDTH-1:0] cd_s;
   logic [WIDTH-1:0] a_s;
   logic [WIDTH-1:0] b_s;
   logic [WIDTH-1:0] c_s;
   logic [WIDTH-1:0] d_s;
   logic [WIDTH-1:0] a_nxt_s;
   logic [WIDTH-1:0] b_nxt_s;
   logic [WIDTH-1:0] c_nxt_s;
   logic [WIDTH-1:0] d_nxt_s;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] c_r;
   logic [WIDTH-1:0] d_r;

   dmux2way_cell #(.WIDTH(WIDTH)) u_stage_hi (
      .sel (sel[1]),
      .in  (in),
      .lo  (ab_s),
      .hi  (cd_s)
   );

   dmux2way_cell #(.WIDTH(WIDTH)) u_stage_ab (
      .sel (sel[0]),
      .in  (ab_s),
      .lo  (a_s),
      .hi  (b_s)
   );

   dmux2way_cell #(.WIDTH(WIDTH)) u_stage_cd (
      .sel (sel[0]),
      .in  (cd_s),
      .lo  (c_s),
      .hi  (d_s)
   );

   // Gate tree outputs by a full decode so an unknown sel loads zeros, never X.
   always_comb begin
      a_nxt_s = '0;
      b_nxt_s = '0;
      c_nxt_s = '0;
      d_nxt_s = '0;
      case (sel)
         SEL_A:   a_nxt_s = a_s;
         SEL_B:   b_nxt_s = b_s;
         SEL_C:   c_nxt_s = c_s;
         SEL_D:   d_nxt_s = d_s;
         default: begin
            a_nxt_s = '0;
            b_nxt_s = '0;
            c_nxt_s = '0;
            d_nxt_s = '0;
         end
      endcase
   end

   // Output register bank, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r <= '0;
         b_r <= '0;
         c_r <= '0;
         d_r <= '0;
      end else begin
         a_r <= a_nxt_s;
         b_r <= b_nxt_s;
         c_r <= c_nxt_s;
         d_r <= d_nxt_s;
      end
   end

   assign a = a_r;
   assign b = b_r;
   assign c = c_r;
   assign d = d_r;

endmodule

// File: tb/tb_dmux4way.sv
// Scoreboard bench for dmux4way at WIDTH=8: expectations queued at drive, checked one edge later.
module tb_dmux4way;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] in_v;
   logic [1:0]   sel_v;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] c;
   logic [W-1:0] d;

   logic [4*W-1:0] sb[$];
   logic [4*W-1:0] exp_v;
   logic [4*W-1:0] got_v;
   int vectors;
   int miscompares;

   dmux4way #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (in_v),
      .sel   (sel_v),
      .a     (a),
      .b     (b),
      .c     (c),
      .d     (d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference demux: unknown select yields all zeros.
   function automatic logic [4*W-1:0] model(input logic [W-1:0] din, input logic [1:0] s);
      logic [4*W-1:0] r;
      r = '0;
      case (s)
         2'b00:   r[4*W-1:3*W] = din;
         2'b01:   r[3*W-1:2*W] = din;
         2'b10:   r[2*W-1:W]   = din;
         2'b11:   r[W-1:0]     = din;
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic int hot_count(input logic [4*W-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         if (v[i*W +: W] != '0) n++;
      end
      return n;
   endfunction

   // Drive one vector at the falling edge, queue its expectation, sample after the next rise.
   task automatic apply(input logic [W-1:0] din, input logic [1:0] s);
      @(negedge clk);
      in_v  = din;
      sel_v = s;
      sb.push_back(model(din, s));
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_v  = 8'h01;
      sel_v = 2'b00;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         got_v = {a, b, c, d};
         vectors++;
         if (got_v !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_hold cyc%0d got=%h exp=%h", i, got_v, 32'h0);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      apply(8'h01, 2'b00);
      exp_v = sb.pop_front();
      got_v = {a, b, c, d};
      vectors++;
      if (got_v !== exp_v) begin
         miscompares++;
         $display("FAIL reset_release got=%h exp=%h", got_v, exp_v);
      end
      // Async clear mid-cycle while a is high.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      got_v = {a, b, c, d};
      vectors++;
      if (got_v !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_async got=%h exp=%h", got_v, 32'h0);
      end
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_zero_sweep();
      for (int s = 0; s < 4; s++) begin
         apply(8'h00, 2'(s));
         exp_v = sb.pop_front();
         got_v = {a, b, c, d};
         vectors++;
         if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL zero_sweep sel=%0d got=%h exp=%h", s, got_v, exp_v);
         end
      end
   endtask

   task automatic test_one_sweep();
      for (int s = 0; s < 4; s++) begin
         apply(8'h01, 2'(s));
         exp_v = sb.pop_front();
         got_v = {a, b, c, d};
         vectors++;
         if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL one_sweep sel=%0d got=%h exp=%h", s, got_v, exp_v);
         end
      end
   endtask

   task automatic test_latency();
      apply(8'h01, 2'b00);
      exp_v = sb.pop_front();
      @(negedge clk);
      in_v  = 8'h01;
      sel_v = 2'b11;
      sb.push_back(model(8'h01, 2'b11));
      #1;
      got_v = {a, b, c, d};
      vectors++;
      if (got_v !== exp_v) begin
         miscompares++;
         $display("FAIL latency_hold got=%h exp=%h", got_v, exp_v);
      end
      @(posedge clk);
      #1;
      exp_v = sb.pop_front();
      got_v = {a, b, c, d};
      vectors++;
      if (got_v !== exp_v || hot_count(got_v) > 1) begin
         miscompares++;
         $display("FAIL latency_switch got=%h exp=%h", got_v, exp_v);
      end
   endtask

   task automatic test_width();
      apply(8'hA5, 2'b10);
      exp_v = sb.pop_front();
      got_v = {a, b, c, d};
      vectors++;
      if (got_v !== exp_v) begin
         miscompares++;
         $display("FAIL width_a5 got=%h exp=%h", got_v, exp_v);
      end
      apply(8'h00, 2'b10);
      exp_v = sb.pop_front();
      got_v = {a, b, c, d};
      vectors++;
      if (got_v !== exp_v) begin
         miscompares++;
         $display("FAIL width_zero got=%h exp=%h", got_v, exp_v);
      end
   endtask

   task automatic test_x_select();
      logic [1:0] xs;
      xs = 2'bx1;
      apply(8'h01, xs);
      exp_v = sb.pop_front();
      got_v = {a, b, c, d};
      vectors++;
      if (got_v !== exp_v || $isunknown(got_v)) begin
         miscompares++;
         $display("FAIL x_select got=%h exp=%h", got_v, exp_v);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] r_in;
      logic [1:0]   r_sel;
      for (int i = 0; i < 24; i++) begin
         r_in  = W'($urandom_range(0, 255));
         r_sel = 2'($urandom_range(0, 3));
         apply(r_in, r_sel);
         exp_v = sb.pop_front();
         got_v = {a, b, c, d};
         vectors++;
         if (got_v !== exp_v || hot_count(got_v) > 1) begin
            miscompares++;
            $display("FAIL back_to_back i=%0d got=%h exp=%h", i, got_v, exp_v);
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      in_v        = '0;
      sel_v       = 2'b00;
      test_reset();
      test_zero_sweep();
      test_one_sweep();
      test_latency();
      test_width();
      test_x_select();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
